// File: rtl/uart_tx_sched.sv
// Round-robin, message-level scheduler that shares one uart_tx byte transmitter
// between NUM_REQ valid/ready byte streams; a grant is held until the message's last byte.
module uart_tx_sched #(
  parameter int          NUM_REQ     = 2,
  parameter logic [15:0] GAP_TIMEOUT = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [1:0]           grant_id,
  output logic                 msg_done,
  output logic                 timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  state_t      state, state_nxt;
  logic        tx_send_nxt, grant_valid_nxt, msg_done_nxt, timeout_nxt;
  logic [7:0]  tx_data_nxt;
  logic [1:0]  grant_id_nxt, rr_ptr, rr_ptr_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        last_flag, last_flag_nxt;

  logic        g_valid, g_last;
  logic [7:0]  g_data;
  logic        sel_found;
  logic [1:0]  sel_id;
  logic [2:0]  cand;

  always_comb begin
    g_valid = 1'b0;
    g_data  = 8'h00;
    g_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == GRANT) && (grant_id == 2'(i));
      if (grant_id == 2'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[8*i +: 8];
        g_last  = req_last[i];
      end
    end
  end

  // Search starts one past the last served requester and wraps modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = 2'd0;
    cand      = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'(rr_ptr) + 3'(k);
      if (cand >= 3'(NUM_REQ))
        cand = cand - 3'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && (cand == 3'(i)) && req_valid[i]) begin
          sel_found = 1'b1;
          sel_id    = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    tx_send_nxt     = tx_send;
    tx_data_nxt     = tx_data;
    grant_valid_nxt = grant_valid;
    grant_id_nxt    = grant_id;
    msg_done_nxt    = 1'b0;
    timeout_nxt     = 1'b0;
    rr_ptr_nxt      = rr_ptr;
    gap_cnt_nxt     = gap_cnt;
    last_flag_nxt   = last_flag;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          grant_id_nxt    = sel_id;
          grant_valid_nxt = 1'b1;
          gap_cnt_nxt     = 16'd0;
          state_nxt       = GRANT;
        end
      end
      GRANT: begin
        if (g_valid) begin
          tx_data_nxt   = g_data;
          tx_send_nxt   = 1'b1;
          last_flag_nxt = g_last;
          state_nxt     = SEND;
        end else begin
          gap_cnt_nxt = gap_cnt + 16'd1;
          if ((GAP_TIMEOUT != 16'd0) && (gap_cnt == GAP_TIMEOUT - 16'd1)) begin
            timeout_nxt     = 1'b1;
            rr_ptr_nxt      = grant_id;
            grant_valid_nxt = 1'b0;
            state_nxt       = IDLE;
          end
        end
      end
      SEND: begin
        // The gap timer is frozen here; a busy transmitter may stall indefinitely.
        if (tx_send && !tx_busy) begin
          tx_send_nxt = 1'b0;
          if (last_flag) begin
            msg_done_nxt    = 1'b1;
            rr_ptr_nxt      = grant_id;
            grant_valid_nxt = 1'b0;
            state_nxt       = IDLE;
          end else begin
            gap_cnt_nxt = 16'd0;
            state_nxt   = GRANT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
      msg_done    <= 1'b0;
      timeout     <= 1'b0;
      rr_ptr      <= 2'(NUM_REQ - 1);
      gap_cnt     <= 16'd0;
      last_flag   <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_send     <= tx_send_nxt;
      tx_data     <= tx_data_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      msg_done    <= msg_done_nxt;
      timeout     <= timeout_nxt;
      rr_ptr      <= rr_ptr_nxt;
      gap_cnt     <= gap_cnt_nxt;
      last_flag   <= last_flag_nxt;
    end
  end

endmodule
